// File: rtl/fib_main.sv
// fib_main: sequential Fibonacci-recurrence engine.
// Runs fib(n, a, b) = (n == 0) ? a : fib(n-1, a+b, a), one iteration per clock.
// A rising edge on r_enable in IDLE captures init_n/init_a/init_b. The final a
// appears on result with a one-cycle w_enable strobe.
// Optional feature: define MAIN_PAUSE_EN so that controlArr=1 freezes the RUN
// state for that cycle. Without it, controlArr is ignored.
module fib_main (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r_enable,
  input  logic        controlArr,
  input  logic [5:0]  init_n,
  input  logic [31:0] init_a,
  input  logic [31:0] init_b,
  output logic        w_enable,
  output logic [31:0] result
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  n_q, n_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        w_enable_q, w_enable_d;
  logic        r_enable_q;
  logic        start;
  logic        pause;

  // Only a low-to-high transition of r_enable counts as a start request.
  assign start = r_enable & ~r_enable_q;

`ifdef MAIN_PAUSE_EN
  assign pause = controlArr;
`else
  assign pause = 1'b0;
  logic unused_control_arr;
  assign unused_control_arr = controlArr;
`endif

  // Next-state and datapath: load in IDLE, iterate in RUN, strobe into DONE.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    w_enable_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = init_n;
          a_d     = init_a;
          b_d     = init_b;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!pause) begin
          if (n_q == 6'd0) begin
            result_d   = a_q;
            w_enable_d = 1'b1;
            state_d    = StDone;
          end else begin
            n_d = n_q - 6'd1;
            a_d = a_q + b_q;  // carry discarded, wraps mod 2^32
            b_d = a_q;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      n_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      w_enable_q <= 1'b0;
      r_enable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      w_enable_q <= w_enable_d;
      r_enable_q <= r_enable;
    end
  end

  assign w_enable = w_enable_q;
  assign result   = result_q;

endmodule

// File: tb/tb_fib_main.sv
// Self-checking bench for fib_main. Expected results and strobe cycles are
// queued when a start is driven; a monitor queues every observed strobe and the
// test tasks pair them up.
module tb_fib_main;

  logic        clk;
  logic        rst_n;
  logic        r_enable;
  logic        controlArr;
  logic [5:0]  init_n;
  logic [31:0] init_a;
  logic [31:0] init_b;
  logic        w_enable;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];
  int    cyc;
  int    checks;
  int    errors;

  fib_main dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_enable  (r_enable),
    .controlArr(controlArr),
    .init_n    (init_n),
    .init_a    (init_a),
    .init_b    (init_b),
    .w_enable  (w_enable),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the edge that produced it.
  always @(negedge clk) begin
    if (w_enable === 1'b1) begin
      item_t it;
      it.res = result;
      it.cyc = cyc;
      obs_q.push_back(it);
    end
  end

  // Pulse r_enable for one cycle; optionally queue the expected completion.
  task automatic start(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int extra, input bit push);
    item_t it;
    @(negedge clk);
    init_n   = n;
    init_a   = a;
    init_b   = b;
    r_enable = 1'b1;
    it.res   = exp_res;
    it.cyc   = cyc + 1 + int'(n) + 1 + extra;
    if (push) exp_q.push_back(it);
    @(negedge clk);
    r_enable = 1'b0;
  endtask

  // Wait (bounded) for the next strobe and compare it against the scoreboard.
  task automatic wait_result(input string name, input int budget);
    item_t o;
    item_t e;
    bit    got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() > 0) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no strobe within %0d cycles, required one", name, budget);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    o = obs_q.pop_front();
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected strobe: result=%0d at cycle %0d, required none",
               name, o.res, o.cyc);
      return;
    end
    e = exp_q.pop_front();
    if (o.res !== e.res) begin
      errors++;
      $display("FAIL %s result: got %0d, required %0d", name, o.res, e.res);
    end
    checks++;
    if (o.cyc !== e.cyc) begin
      errors++;
      $display("FAIL %s strobe cycle: got %0d, required %0d", name, o.cyc, e.cyc);
    end
    @(negedge clk);
    #1;
    checks++;
    if (w_enable !== 1'b0) begin
      errors++;
      $display("FAIL %s strobe width: w_enable=%b one cycle later, required 0", name, w_enable);
    end
    checks++;
    if (result !== e.res) begin
      errors++;
      $display("FAIL %s result hold: got %0d, required %0d", name, result, e.res);
    end
  endtask

  // Check that no strobe arrived beyond those already consumed.
  task automatic check_no_strobe(input string name, input int cycles);
    repeat (cycles) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s extra strobes: got %0d, required 0", name, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (w_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset w_enable: got %b, required 0", w_enable);
    end
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL reset result: got %0d, required 0", result);
    end
    check_no_strobe("reset_idle", 6);
  endtask

  task automatic test_f41();
    start(6'd40, 32'd1, 32'd0, 32'd165580141, 0, 1'b1);
    wait_result("f41", 60);
  endtask

  task automatic test_small();
    start(6'd0, 32'h1234_5678, 32'd7, 32'h1234_5678, 0, 1'b1);
    wait_result("n0", 10);
    start(6'd1, 32'd1, 32'd0, 32'd1, 0, 1'b1);
    wait_result("n1", 10);
  endtask

  task automatic test_wrap();
    start(6'd47, 32'd1, 32'd0, 32'd512559680, 0, 1'b1);
    wait_result("wrap", 70);
  endtask

  task automatic test_retrigger();
    item_t it;
    // n=10, a=1, b=0 -> F11 = 89; r_enable re-rises mid-RUN and then stays high.
    @(negedge clk);
    init_n   = 6'd10;
    init_a   = 32'd1;
    init_b   = 32'd0;
    r_enable = 1'b1;
    it.res   = 32'd89;
    it.cyc   = cyc + 1 + 11;
    exp_q.push_back(it);
    repeat (3) @(negedge clk);
    r_enable = 1'b0;
    @(negedge clk);
    init_n   = 6'd3;
    init_a   = 32'd99;
    r_enable = 1'b1;
    wait_result("retrig_run", 30);
    check_no_strobe("retrig_level", 10);
    r_enable = 1'b0;
    @(negedge clk);
    // fib(2, 3, 2) = 8
    start(6'd2, 32'd3, 32'd2, 32'd8, 0, 1'b1);
    wait_result("retrig_fresh", 10);
  endtask

  task automatic test_reset_mid();
    start(6'd40, 32'd1, 32'd0, 32'd0, 0, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid result: got %0d, required 0", result);
    end
    check_no_strobe("reset_mid_abort", 50);
    start(6'd40, 32'd1, 32'd0, 32'd165580141, 0, 1'b1);
    wait_result("reset_mid_fresh", 60);
  endtask

  task automatic test_pause();
    int extra;
`ifdef MAIN_PAUSE_EN
    extra = 5;
`else
    extra = 0;
`endif
    start(6'd40, 32'd1, 32'd0, 32'd165580141, extra, 1'b1);
    controlArr = 1'b1;
    repeat (5) @(negedge clk);
    controlArr = 1'b0;
    wait_result("pause", 60);
  endtask

  initial begin
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    r_enable   = 1'b0;
    controlArr = 1'b0;
    init_n     = '0;
    init_a     = '0;
    init_b     = '0;
    test_reset();
    test_f41();
    test_small();
    test_wrap();
    test_retrigger();
    test_reset_mid();
    test_pause();
    check_no_strobe("final", 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
